// File: rtl/ma_decim_fifo.sv
// Downstream stage of the 8-tap moving-average filter. It drops the filter's
// start-up transient, keeps one of every DECIM samples after that, and queues
// the kept samples in a show-ahead FIFO with a valid/ready output.
module ma_decim_fifo #(
  parameter int DATA_W = 16,
  parameter int DECIM  = 8,
  parameter int WARMUP = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  input  logic                     clear_ovf,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [WW-1:0] WARM_LAST  = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);

  typedef enum logic {
    ST_WARM,
    ST_RUN
  } state_t;

  // With no settling length the stage comes out of reset already running.
  localparam state_t ST_RESET = (WARMUP == 0) ? ST_RUN : ST_WARM;

  state_t          state_q, state_d;
  logic [WW-1:0]   warm_q, warm_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            keep;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_q, rd_q;
  logic              full, empty, pop, push_ok, drop;

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
      warm_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      phase_q <= phase_d;
    end
  end

  // Sequencer next state: counts off the warmup, then cycles the decimation phase.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    phase_d = phase_q;
    if (enable) begin
      unique case (state_q)
        ST_WARM: begin
          if (warm_q == WARM_LAST) begin
            state_d = ST_RUN;
            warm_d  = '0;
            phase_d = '0;
          end else begin
            warm_d = warm_q + WW'(1);
          end
        end
        ST_RUN: begin
          phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
        end
        default: state_d = ST_RESET;
      endcase
    end
  end

  // Sequencer output: a sample is kept on the first phase of each decimation period.
  always_comb begin
    keep = enable && (state_q == ST_RUN) && (phase_q == '0);
  end

  // FIFO status and handshake decode.
  always_comb begin
    empty     = (wr_q == rd_q);
    full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    out_valid = !empty;
    pop       = out_valid && out_ready;
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    push_ok   = keep && (!full || pop);
    drop      = keep && full && !pop;
    out_data  = out_valid ? mem[rd_q[AW-1:0]] : '0;
    fill_level = wr_q - rd_q;
  end

  // FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + (AW+1)'(1);
      if (pop)     rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // FIFO storage, not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= din;
  end

  // Sticky overflow flag; a new drop wins over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ma_decim_fifo.sv
// Directed bench for ma_decim_fifo with a queue-based scoreboard of kept samples.
module tb_ma_decim_fifo;

  localparam int DATA_W = 16;
  localparam int DECIM  = 8;
  localparam int WARMUP = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [$clog2(DEPTH):0] fill_level;
  logic              clear_ovf = 1'b0;
  logic              overflow;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] q[$];
  int   n_m   = 0;
  logic ovf_m = 1'b0;

  ma_decim_fifo #(
    .DATA_W(DATA_W),
    .DECIM (DECIM),
    .WARMUP(WARMUP),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .din       (din),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill_level(fill_level),
    .clear_ovf (clear_ovf),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: checks outputs against the model, drives inputs,
  // advances the model across the next rising edge, returns at the next falling edge.
  task automatic step(input logic en, input logic [DATA_W-1:0] d, input logic rdy, input logic clr);
    logic keep, pop;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_data", 32'(out_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("fill_level", 32'(fill_level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    enable = en; din = d; out_ready = rdy; clear_ovf = clr;
    pop  = rdy && (q.size() != 0);
    keep = en && (n_m >= WARMUP) && (((n_m - WARMUP) % DECIM) == 0);
    if (en) n_m++;
    if (pop) void'(q.pop_front());
    if (clr) ovf_m = 1'b0;
    if (keep) begin
      if (q.size() < DEPTH) q.push_back(d);
      else ovf_m = 1'b1;
    end
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle and checks the outputs clear before any clock edge.
  task automatic do_reset();
    enable = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    q.delete(); n_m = 0; ovf_m = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Constant full-scale input
    for (int i = 0; i < 40; i++) step(1'b1, 16'h7FFF, 1'b1, 1'b0);

    // Positive ramp
    do_reset();
    for (int n = 0; n < 80; n++) step(1'b1, 16'(n), 1'b1, 1'b0);

    // Negative ramp
    do_reset();
    for (int n = 0; n < 80; n++) step(1'b1, 16'(0 - n), 1'b1, 1'b0);

    // Fill with consumer stalled, overflow on 136, then drain
    do_reset();
    for (int n = 0; n <= 136; n++) step(1'b1, 16'(n), 1'b0, 1'b0);
    chk("full_fill", 32'(fill_level), 32'd16);
    chk("full_head", 32'(out_data), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd1);
    for (int n = 137; n < 320; n++) step(1'b1, 16'(n), 1'b1, 1'b0);

    // Hold full with pops only on kept cycles, then clear coinciding with a drop
    do_reset();
    for (int n = 0; n < 136; n++) step(1'b1, 16'(n), 1'b0, 1'b0);
    for (int n = 136; n < 176; n++) step(1'b1, 16'(n), (n % DECIM) == 0, 1'b0);
    chk("hold_fill", 32'(fill_level), 32'd16);
    chk("hold_ovf", 32'(overflow), 32'd0);
    for (int n = 176; n < 184; n++) step(1'b1, 16'(n), 1'b0, n == 176);
    chk("clr_drop_ovf", 32'(overflow), 32'd1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Enable toggling; garbage on disabled cycles must be ignored
    do_reset();
    for (int n = 0; n < 60; n++) begin
      step(1'b1, 16'(n), 1'b1, 1'b0);
      step(1'b0, 16'hDEAD, 1'b1, 1'b0);
    end

    // Reset with five buffered entries, then warmup restarts
    do_reset();
    for (int n = 0; n <= 40; n++) step(1'b1, 16'(n), 1'b0, 1'b0);
    chk("pre_rst_fill", 32'(fill_level), 32'd5);
    do_reset();
    for (int n = 0; n < 30; n++) step(1'b1, 16'(1000 + n), 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
